// File: rtl/led_pattern_ctrl_if.sv
// Configuration channel for led_pattern_ctrl: valid/ready handshake carrying
// mode, two patterns and a brightness level.
interface led_pattern_ctrl_if #(
  parameter int NUM_LEDS = 4,
  parameter int PWM_BITS = 4
);
  logic                cfg_valid;
  logic                cfg_ready;
  logic [1:0]          cfg_mode;
  logic [NUM_LEDS-1:0] cfg_pat_a;
  logic [NUM_LEDS-1:0] cfg_pat_b;
  logic [PWM_BITS-1:0] cfg_bright;

  modport master (
    output cfg_valid, cfg_mode, cfg_pat_a, cfg_pat_b, cfg_bright,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_pat_a, cfg_pat_b, cfg_bright,
    output cfg_ready
  );
endinterface

// File: rtl/led_pattern_ctrl.sv
// Status-LED driver: STATIC/BLINK/CHASE/BREATHE rendering with PWM dimming.
// Configurations are staged in a shadow register and only go live on a tick.
module led_pattern_ctrl #(
  parameter int                  NUM_LEDS = 4,
  parameter int                  TICK_DIV = 6_250_000,
  parameter int                  PWM_BITS = 4,
  parameter logic [NUM_LEDS-1:0] RST_PAT  = {{(NUM_LEDS-1){1'b0}}, 1'b1}
) (
  input  logic                clk,
  input  logic                rst,
  led_pattern_ctrl_if.slave   cfg,
  output logic                tick,
  output logic [NUM_LEDS-1:0] leds
);
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CH_W  = $clog2(NUM_LEDS);

  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0]    DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0]    DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [CH_W-1:0]     CH_LAST  = CH_W'(NUM_LEDS - 1);
  localparam logic [CH_W-1:0]     CH_ONE   = CH_W'(1);
  localparam logic [CH_W-1:0]     CH_ZERO  = {CH_W{1'b0}};
  localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] PWM_FULL = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] PWM_ZERO = {PWM_BITS{1'b0}};
  localparam logic [NUM_LEDS-1:0] PAT_ZERO = {NUM_LEDS{1'b0}};

  localparam logic [1:0] MODE_STATIC  = 2'd0;
  localparam logic [1:0] MODE_BLINK   = 2'd1;
  localparam logic [1:0] MODE_CHASE   = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  typedef enum logic {ST_IDLE = 1'b0, ST_PENDING = 1'b1} hs_state_e;

  hs_state_e           r_state, w_state_nxt;
  logic                r_ready;
  logic [DIV_W-1:0]    r_div;
  logic                r_tick;
  logic                w_wrap, w_accept, w_apply;

  logic [1:0]          r_sh_mode, r_mode;
  logic [NUM_LEDS-1:0] r_sh_pat_a, r_sh_pat_b, r_pat_a, r_pat_b;
  logic [PWM_BITS-1:0] r_sh_bright, r_bright;

  logic                r_phase;
  logic [CH_W-1:0]     r_chase_idx;
  logic [PWM_BITS-1:0] r_level, w_level_nxt;
  logic                r_dir_up, w_dir_up_nxt;
  logic [PWM_BITS-1:0] r_pwm;
  logic [NUM_LEDS-1:0] r_leds, w_rot, w_pattern;
  logic [PWM_BITS-1:0] w_duty;
  logic                w_on;

  assign w_wrap = (r_div == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div  <= DIV_ZERO;
      r_tick <= 1'b0;
      r_pwm  <= PWM_ZERO;
    end else begin
      r_div  <= w_wrap ? DIV_ZERO : (r_div + DIV_ONE);
      r_tick <= w_wrap;
      r_pwm  <= r_pwm + PWM_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == ST_IDLE);
    end
  end

  // A config captured at the wrap edge itself waits for the following wrap.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_apply     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cfg.cfg_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_PENDING;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PENDING: begin
        if (w_wrap) begin
          w_apply     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_PENDING;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_mode   <= MODE_STATIC;
      r_sh_pat_a  <= PAT_ZERO;
      r_sh_pat_b  <= PAT_ZERO;
      r_sh_bright <= PWM_ZERO;
    end else if (w_accept) begin
      r_sh_mode   <= cfg.cfg_mode;
      r_sh_pat_a  <= cfg.cfg_pat_a;
      r_sh_pat_b  <= cfg.cfg_pat_b;
      r_sh_bright <= cfg.cfg_bright;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode      <= MODE_STATIC;
      r_pat_a     <= RST_PAT;
      r_pat_b     <= PAT_ZERO;
      r_bright    <= PWM_FULL;
      r_phase     <= 1'b0;
      r_chase_idx <= CH_ZERO;
      r_level     <= PWM_ZERO;
      r_dir_up    <= 1'b1;
    end else if (w_wrap) begin
      if (w_apply) begin
        r_mode      <= r_sh_mode;
        r_pat_a     <= r_sh_pat_a;
        r_pat_b     <= r_sh_pat_b;
        r_bright    <= r_sh_bright;
        r_phase     <= 1'b0;
        r_chase_idx <= CH_ZERO;
        r_level     <= PWM_ZERO;
        r_dir_up    <= 1'b1;
      end else begin
        r_phase     <= ~r_phase;
        r_chase_idx <= (r_chase_idx == CH_LAST) ? CH_ZERO : (r_chase_idx + CH_ONE);
        r_level     <= w_level_nxt;
        r_dir_up    <= w_dir_up_nxt;
      end
    end
  end

  // Triangle ramp: the direction flips on reaching an endpoint, so each endpoint lasts one tick.
  always_comb begin
    w_level_nxt  = r_level;
    w_dir_up_nxt = r_dir_up;
    if ((r_mode != MODE_BREATHE) || (r_bright == PWM_ZERO)) begin
      w_level_nxt  = PWM_ZERO;
      w_dir_up_nxt = 1'b1;
    end else if (r_dir_up) begin
      w_level_nxt  = r_level + PWM_ONE;
      w_dir_up_nxt = (w_level_nxt != r_bright);
    end else begin
      w_level_nxt  = r_level - PWM_ONE;
      w_dir_up_nxt = (w_level_nxt == PWM_ZERO);
    end
  end

  always_comb begin
    w_rot = PAT_ZERO;
    for (int i = 0; i < NUM_LEDS; i++) begin
      w_rot[(i + int'(r_chase_idx)) % NUM_LEDS] = r_pat_a[i];
    end
  end

  always_comb begin
    w_pattern = r_pat_a;
    case (r_mode)
      MODE_STATIC:  w_pattern = r_pat_a;
      MODE_BLINK:   w_pattern = r_phase ? r_pat_b : r_pat_a;
      MODE_CHASE:   w_pattern = w_rot;
      MODE_BREATHE: w_pattern = r_pat_a;
      default:      w_pattern = r_pat_a;
    endcase
  end

  assign w_duty = (r_mode == MODE_BREATHE) ? r_level : r_bright;
  assign w_on   = (w_duty == PWM_FULL) | (r_pwm < w_duty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_leds <= PAT_ZERO;
    end else begin
      r_leds <= w_pattern & {NUM_LEDS{w_on}};
    end
  end

  assign tick          = r_tick;
  assign leds          = r_leds;
  assign cfg.cfg_ready = r_ready;
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Randomized + directed bench for led_pattern_ctrl, checked every cycle
// against a tick-count based behavioural model.
module tb_led_pattern_ctrl;
  localparam int NL = 4;
  localparam int TD = 8;
  localparam int PB = 4;
  localparam logic [NL-1:0] RP = 4'b0001;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tick;
  logic [NL-1:0] leds;

  led_pattern_ctrl_if #(.NUM_LEDS(NL), .PWM_BITS(PB)) cfg_if ();

  led_pattern_ctrl #(
    .NUM_LEDS(NL), .TICK_DIV(TD), .PWM_BITS(PB), .RST_PAT(RP)
  ) dut (
    .clk(clk), .rst(rst), .cfg(cfg_if), .tick(tick), .leds(leds)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Model: k = clock edges since reset release, n = ticks since last apply.
  int            m_k, m_n;
  logic          m_pend;
  logic [1:0]    m_mode, s_mode;
  logic [NL-1:0] m_pa, m_pb, s_pa, s_pb;
  logic [PB-1:0] m_br, s_br;
  logic [NL-1:0] exp_leds;
  logic          exp_tick, exp_ready;

  function automatic int tri_level(int n, int b);
    int m;
    if (b == 0) return 0;
    m = n % (2 * b);
    return (m <= b) ? m : (2 * b - m);
  endfunction

  function automatic logic [NL-1:0] model_pattern();
    int v;
    int s;
    case (m_mode)
      2'd1: return (m_n % 2 == 1) ? m_pb : m_pa;
      2'd2: begin
        s = m_n % NL;
        v = int'(m_pa);
        v = ((v << s) | (v >> (NL - s))) & ((1 << NL) - 1);
        return v[NL-1:0];
      end
      default: return m_pa;
    endcase
  endfunction

  task automatic model_edge();
    int   duty;
    logic on, wrap, old_p;
    if (rst) begin
      m_k = 0; m_n = 0; m_pend = 1'b0;
      m_mode = 2'd0; m_pa = RP; m_pb = 4'b0000; m_br = 4'hF;
      exp_leds = 4'b0000; exp_tick = 1'b0; exp_ready = 1'b1;
      return;
    end
    duty     = (m_mode == 2'd3) ? tri_level(m_n, int'(m_br)) : int'(m_br);
    on       = (duty == (1 << PB) - 1) || ((m_k % (1 << PB)) < duty);
    exp_leds = on ? model_pattern() : 4'b0000;
    wrap     = ((m_k % TD) == TD - 1);
    exp_tick = wrap;
    old_p    = m_pend;
    if (cfg_if.cfg_valid && !old_p) begin
      m_pend = 1'b1;
      s_mode = cfg_if.cfg_mode; s_pa = cfg_if.cfg_pat_a;
      s_pb = cfg_if.cfg_pat_b;  s_br = cfg_if.cfg_bright;
    end
    if (wrap) begin
      if (old_p) begin
        m_mode = s_mode; m_pa = s_pa; m_pb = s_pb; m_br = s_br;
        m_n = 0; m_pend = 1'b0;
      end else begin
        m_n++;
      end
    end
    exp_ready = !m_pend;
    m_k++;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    model_edge();
    @(negedge clk);
    chk("leds",  32'(leds), 32'(exp_leds));
    chk("tick",  32'(tick), 32'(exp_tick));
    chk("ready", 32'(cfg_if.cfg_ready), 32'(exp_ready));
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 2 * TD; i++) begin
      step();
      if (tick) return;
    end
    chk("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_cfg(logic [1:0] mode, logic [NL-1:0] pa, logic [NL-1:0] pb, logic [PB-1:0] br);
    logic was_ready;
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_mode = mode;
    cfg_if.cfg_pat_a = pa;   cfg_if.cfg_pat_b = pb; cfg_if.cfg_bright = br;
    for (int i = 0; i < 3 * TD; i++) begin
      was_ready = cfg_if.cfg_ready;
      step();
      if (was_ready) begin
        cfg_if.cfg_valid = 1'b0;
        return;
      end
    end
    cfg_if.cfg_valid = 1'b0;
    chk("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic count_lit(int n, logic [NL-1:0] pat, output int lit);
    lit = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (leds == pat) lit++;
    end
  endtask

  logic [NL-1:0] blink_exp [4] = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
  logic [NL-1:0] chase_exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int            tri_exp   [6] = '{0, 1, 2, 1, 0, 1};

  initial begin
    int lit;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_mode = 2'd0;
    cfg_if.cfg_pat_a = 4'b0000; cfg_if.cfg_pat_b = 4'b0000; cfg_if.cfg_bright = 4'h0;

    for (int i = 0; i < 6; i++) chk("tri_model", 32'(tri_level(i, 2)), 32'(tri_exp[i]));

    #1 rst = 1'b1;
    repeat (3) step();
    chk("rst_leds_lit", 32'(leds), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 0) chk("post_rst_leds_lit", 32'(leds), 32'(4'b0001));
      chk("tick_period_lit", 32'(tick), (i % TD == TD - 1) ? 32'd1 : 32'd0);
    end

    // STATIC 1010 sent between ticks
    repeat (2) step();
    send_cfg(2'd0, 4'b1010, 4'b0000, 4'hF);
    chk("ready_low_lit", 32'(cfg_if.cfg_ready), 32'd0);
    wait_tick();
    chk("ready_back_lit", 32'(cfg_if.cfg_ready), 32'd1);
    step();
    chk("static_lit", 32'(leds), 32'(4'b1010));

    // BLINK 1100/0011
    send_cfg(2'd1, 4'b1100, 4'b0011, 4'hF);
    wait_tick(); step();
    chk("blink0_lit", 32'(leds), 32'(4'b1100));
    for (int i = 0; i < 4; i++) begin
      wait_tick(); step();
      chk("blink_lit", 32'(leds), 32'(blink_exp[i]));
    end

    // CHASE 0001
    send_cfg(2'd2, 4'b0001, 4'b0000, 4'hF);
    wait_tick(); step();
    chk("chase0_lit", 32'(leds), 32'(4'b0001));
    for (int i = 0; i < 4; i++) begin
      wait_tick(); step();
      chk("chase_lit", 32'(leds), 32'(chase_exp[i]));
    end

    // PWM duty: bright=4 lights 4 of 16 cycles, bright=0 stays dark
    send_cfg(2'd0, 4'hF, 4'h0, 4'h4);
    wait_tick(); step();
    count_lit(16, 4'hF, lit);
    chk("pwm4_lit", 32'(lit), 32'd4);
    send_cfg(2'd0, 4'hF, 4'h0, 4'h0);
    wait_tick(); step();
    count_lit(16, 4'hF, lit);
    chk("pwm0_lit", 32'(lit), 32'd0);

    // Handshake in the tick cycle applies at the next tick
    send_cfg(2'd0, 4'b0110, 4'b0000, 4'hF);
    wait_tick(); step();
    wait_tick();
    send_cfg(2'd0, 4'b1111, 4'b0000, 4'hF);
    chk("tick_cycle_not_applied_lit", 32'(leds), 32'(4'b0110));
    wait_tick(); step();
    chk("tick_cycle_applied_lit", 32'(leds), 32'(4'b1111));

    // Valid held through pending: second config captured once ready returns
    send_cfg(2'd0, 4'b0101, 4'b0000, 4'hF);
    send_cfg(2'd0, 4'b1001, 4'b0000, 4'hF);
    chk("held_first_lit", 32'(leds), 32'(4'b0101));
    wait_tick(); step();
    chk("held_second_lit", 32'(leds), 32'(4'b1001));

    // BREATHE bright=2: dark through the first tick period (level 0)
    send_cfg(2'd3, 4'hF, 4'h0, 4'h2);
    wait_tick();
    count_lit(TD, 4'hF, lit);
    chk("breathe_l0_lit", 32'(lit), 32'd0);
    repeat (6 * TD) step();

    // Reset while pending discards the config
    send_cfg(2'd0, 4'b1110, 4'b0000, 4'hF);
    rst = 1'b1;
    #1 chk("rst_async_lit", 32'(leds), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("rst_pend_leds_lit", 32'(leds), 32'(RP));
    wait_tick(); step();
    chk("rst_discard_lit", 32'(leds), 32'(RP));

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      cfg_if.cfg_valid  = ($urandom_range(0, 5) == 0);
      cfg_if.cfg_mode   = 2'($urandom_range(0, 3));
      cfg_if.cfg_pat_a  = 4'($urandom_range(0, 15));
      cfg_if.cfg_pat_b  = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 4))
        0: cfg_if.cfg_bright = 4'h0;
        1: cfg_if.cfg_bright = 4'hF;
        2: cfg_if.cfg_bright = 4'h1;
        default: cfg_if.cfg_bright = 4'($urandom_range(0, 15));
      endcase
      step();
    end
    rst = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    repeat (2 * TD) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
